mac_burst_counter: RTL and testbench
====================================

// Module: mac_burst_counter
// PURPOSE
//   Parametrised burst/tile counter for the systolic MAC output path. It counts
//   'done' pulses from the PE array. After a runtime-programmable number of pulses
//   it raises en_y, holding it until the downstream y_ready handshake completes.
//   Bursts repeat for a programmable tile count, with last-tile and completion
//   flags. Overflow pulses arriving while a result is pending are detected.
// PARAMETERS
//   CNT_W    8  width of burst-length config and pulse counter
//   TILE_W   8  width of tile-count config and tile index
//   DEF_LEN  7  burst length used when cfg_len==0 at start
// PORTS
//   clk        in   1       rising-edge clock
//   reset      in   1       asynchronous active-high reset
//   clr        in   1       synchronous abort: return to IDLE, clear err_ovf
//   start      in   1       launch a job; sampled only in IDLE
//   cfg_len    in   CNT_W   pulses per burst (0 => DEF_LEN), latched on start
//   cfg_tiles  in   TILE_W  bursts per job (0 => 1), latched on start
//   done       in   1       one pulse = one accepted MAC result
//   y_ready    in   1       downstream ready for the en_y handshake
//   en_y       out  1       burst complete; held until y_ready
//   busy       out  1       high in every state except IDLE
//   count      out  CNT_W   pulses received in the current burst
//   tile_idx   out  TILE_W  index of the current burst, 0-based
//   last_tile  out  1       tile_idx == latched tiles-1 while busy
//   all_done   out  1       one-cycle pulse after the final handshake
//   err_ovf    out  1       sticky: done seen while en_y pending
// BEHAVIOUR
//   Reset: all outputs are 0; state is IDLE; latched len is DEF_LEN; latched tiles is 1.
//   reset is asynchronous and active-high; asserting it mid-job aborts at once.
//   FSM states: IDLE, COUNT, EMIT, FIN.
//   IDLE -> COUNT on start:
//     - latch len and tiles, applying the zero substitutions above
//     - count <= 0, tile_idx <= 0
//   COUNT:
//     - each done cycle does count++
//     - when done and count == len-1: count <= len and go to EMIT
//     - en_y rises on the next cycle (registered), so latency is 1 clk from the final done
//   EMIT:
//     - en_y = 1 and is held while y_ready is low
//     - handshake = en_y & y_ready
//     - on handshake, if not last_tile: tile_idx++, count <= 0, go to COUNT
//     - on handshake, if last_tile: go to FIN
//     - done during EMIT is not counted and sets err_ovf
//   FIN: all_done = 1 for exactly one cycle, then IDLE; busy drops in IDLE.
//   start outside IDLE is ignored. cfg_* changes after start have no effect.
//   clr has priority over every other input:
//     - next state is IDLE
//     - count, tile_idx, en_y and err_ovf are cleared
//   Simultaneous events:
//     - done on the same cycle as the handshake is the first pulse of the next
//       burst (count <= 1), unless this is the last tile; then it is ignored and sets err_ovf
//     - start on the same cycle as clr is ignored
//   len == 1: every done causes EMIT, so back-to-back bursts are possible.
//   Wrap: count never exceeds len and tile_idx never exceeds tiles-1, so there is no
//   modular wrap. The maximum config is 2^CNT_W-1 pulses and 2^TILE_W-1 tiles.
// TESTING
//   1. start with cfg_len=0, cfg_tiles=0, then 7 done pulses spaced 1 clk, y_ready=1
//      -> en_y 1 clk after the 7th pulse, then all_done, then busy=0.
//   2. cfg_len=3, cfg_tiles=4, y_ready=1, 12 pulses
//      -> 4 en_y handshakes; tile_idx 0..3; last_tile only on tile 3; one all_done.
//   3. cfg_len=2, y_ready held 0 for 5 clk, 1 done pulse during EMIT
//      -> en_y stays 1 until y_ready; err_ovf=1 and stays 1; count stays 2.
//   4. cfg_len=2, cfg_tiles=2, done on the same cycle as the first handshake
//      -> count=1 in burst 2; the second en_y comes after 1 more pulse; err_ovf=0.
//   5. Assert reset asynchronously mid-burst (count=3), then clr mid-EMIT in a second job
//      -> outputs go to 0 immediately on reset and the next cycle on clr; a later start behaves per test 1.
//   6. cfg_len=1, cfg_tiles=3, y_ready=1, 3 consecutive done pulses
//      -> 3 handshakes and all_done; no err_ovf.

Source files
------------

// File: rtl/mac_burst_counter.sv
// Burst/tile counter for the systolic MAC output path: counts done pulses, raises en_y per burst.
// Latency: en_y rises 1 clk after the final done of a burst; all_done 1 clk after the last handshake.
// Backpressure: en_y is held until y_ready; done pulses while a result is pending set sticky err_ovf.
module mac_burst_counter #(
   parameter int CNT_W   = 8,
   parameter int TILE_W  = 8,
   parameter int DEF_LEN = 7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              start,
   input  logic [CNT_W-1:0]  cfg_len,
   input  logic [TILE_W-1:0] cfg_tiles,
   input  logic              done,
   input  logic              y_ready,
   output logic              en_y,
   output logic              busy,
   output logic [CNT_W-1:0]  count,
   output logic [TILE_W-1:0] tile_idx,
   output logic              last_tile,
   output logic              all_done,
   output logic              err_ovf
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      EMIT  = 2'd2,
      FIN   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0]  ONE_C   = CNT_W'(1);
   localparam logic [TILE_W-1:0] ONE_T   = TILE_W'(1);
   localparam logic [CNT_W-1:0]  DEF_L_C = CNT_W'(DEF_LEN);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    len_q, len_d;
   logic [TILE_W-1:0]   tiles_q, tiles_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [TILE_W-1:0]   tile_q, tile_d;
   logic                ovf_q, ovf_d;
   logic                is_last;

   assign is_last = (tile_q == (tiles_q - ONE_T));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         len_q   <= DEF_L_C;
         tiles_q <= ONE_T;
         count_q <= '0;
         tile_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         tiles_q <= tiles_d;
         count_q <= count_d;
         tile_q  <= tile_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      tiles_d = tiles_q;
      count_d = count_q;
      tile_d  = tile_q;
      ovf_d   = ovf_q;

      if (clr) begin
         state_d = IDLE;
         count_d = '0;
         tile_d  = '0;
         ovf_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  len_d   = (cfg_len == '0)   ? DEF_L_C : cfg_len;
                  tiles_d = (cfg_tiles == '0) ? ONE_T   : cfg_tiles;
                  count_d = '0;
                  tile_d  = '0;
                  state_d = COUNT;
               end
            end
            COUNT: begin
               if (done) begin
                  count_d = count_q + ONE_C;
                  if (count_q == (len_q - ONE_C)) begin
                     state_d = EMIT;
                  end
               end
            end
            EMIT: begin
               if (y_ready) begin
                  if (is_last) begin
                     state_d = FIN;
                     if (done) begin
                        ovf_d = 1'b1;
                     end
                  end else begin
                     // A done coinciding with the handshake opens the next burst; with len 1 it also closes it.
                     tile_d  = tile_q + ONE_T;
                     count_d = {{(CNT_W-1){1'b0}}, done};
                     state_d = (done && (len_q == ONE_C)) ? EMIT : COUNT;
                  end
               end else if (done) begin
                  ovf_d = 1'b1;
               end
            end
            FIN: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   assign en_y      = (state_q == EMIT);
   assign busy      = (state_q != IDLE);
   assign all_done  = (state_q == FIN);
   assign last_tile = busy && is_last;
   assign count     = count_q;
   assign tile_idx  = tile_q;
   assign err_ovf   = ovf_q;

endmodule

// File: tb/tb_mac_burst_counter.sv
// Directed and randomized bench for mac_burst_counter against a behavioural job model.
module tb_mac_burst_counter;

   logic       clk = 1'b0;
   logic       reset;
   logic       clr, start, done, y_ready;
   logic [7:0] cfg_len, cfg_tiles;
   logic       en_y, busy, last_tile, all_done, err_ovf;
   logic [7:0] count, tile_idx;

   int n_pass = 0;
   int n_fail = 0;
   int n_tot  = 0;
   int hs_cnt = 0;
   int ad_cnt = 0;

   // Model: a job is "busy", a finished burst is "pending" until taken, "fin" marks the wrap-up cycle.
   int m_busy, m_pend, m_fin, m_cnt, m_tile, m_ovf, m_len, m_tiles;

   always #5 clk = ~clk;

   mac_burst_counter #(.CNT_W(8), .TILE_W(8), .DEF_LEN(7)) dut (
      .clk       (clk),
      .reset     (reset),
      .clr       (clr),
      .start     (start),
      .cfg_len   (cfg_len),
      .cfg_tiles (cfg_tiles),
      .done      (done),
      .y_ready   (y_ready),
      .en_y      (en_y),
      .busy      (busy),
      .count     (count),
      .tile_idx  (tile_idx),
      .last_tile (last_tile),
      .all_done  (all_done),
      .err_ovf   (err_ovf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_pend = 0; m_fin = 0; m_cnt = 0; m_tile = 0; m_ovf = 0;
      m_len = 7; m_tiles = 1;
   endtask

   task automatic model_step(input logic s, input logic d, input logic yr, input logic c);
      if (c) begin
         m_busy = 0; m_pend = 0; m_fin = 0; m_cnt = 0; m_tile = 0; m_ovf = 0;
      end else if (m_busy == 0) begin
         if (s) begin
            m_busy  = 1;
            m_len   = (cfg_len == 0) ? 7 : int'(cfg_len);
            m_tiles = (cfg_tiles == 0) ? 1 : int'(cfg_tiles);
            m_cnt   = 0;
            m_tile  = 0;
         end
      end else if (m_fin != 0) begin
         m_fin  = 0;
         m_busy = 0;
      end else if (m_pend != 0) begin
         if (yr) begin
            if (m_tile == m_tiles - 1) begin
               m_pend = 0;
               m_fin  = 1;
               if (d) m_ovf = 1;
            end else begin
               m_tile = m_tile + 1;
               m_cnt  = d ? 1 : 0;
               m_pend = (d && m_len == 1) ? 1 : 0;
            end
         end else if (d) begin
            m_ovf = 1;
         end
      end else if (d) begin
         m_cnt = m_cnt + 1;
         if (m_cnt == m_len) m_pend = 1;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".en_y"},      32'(en_y),      32'(m_pend));
      chk({tag, ".busy"},      32'(busy),      32'(m_busy));
      chk({tag, ".all_done"},  32'(all_done),  32'(m_fin));
      chk({tag, ".count"},     32'(count),     32'(m_cnt));
      chk({tag, ".tile_idx"},  32'(tile_idx),  32'(m_tile));
      chk({tag, ".last_tile"}, 32'(last_tile), (m_busy != 0 && m_tile == m_tiles - 1) ? 32'd1 : 32'd0);
      chk({tag, ".err_ovf"},   32'(err_ovf),   32'(m_ovf));
   endtask

   task automatic tick(input string tag, input logic s, input logic d, input logic yr, input logic c);
      start = s; done = d; y_ready = yr; clr = c;
      if (en_y && yr && !c) hs_cnt++;
      @(posedge clk);
      model_step(s, d, yr, c);
      #1;
      check_all(tag);
      if (all_done) ad_cnt++;
      start = 1'b0; done = 1'b0; clr = 1'b0;
   endtask

   task automatic async_rst(input string tag);
      #2 reset = 1'b1;
      model_reset();
      #1 check_all({tag, ".now"});
      @(posedge clk);
      #1 check_all({tag, ".hold"});
      reset = 1'b0;
   endtask

   task automatic run_default_job(input string tag);
      cfg_len = 8'd0; cfg_tiles = 8'd0;
      tick({tag, ".start"}, 1, 0, 1, 0);
      cfg_len = 8'd3; cfg_tiles = 8'd5;
      for (int i = 0; i < 7; i++) tick({tag, ".pulse"}, 0, 1, 1, 0);
      chk({tag, ".en_y_after_7"}, 32'(en_y), 32'd1);
      tick({tag, ".hs"}, 0, 0, 1, 0);
      chk({tag, ".all_done"}, 32'(all_done), 32'd1);
      tick({tag, ".idle"}, 0, 0, 1, 0);
      chk({tag, ".busy_low"}, 32'(busy), 32'd0);
   endtask

   initial begin
      reset = 1'b1; clr = 1'b0; start = 1'b0; done = 1'b0; y_ready = 1'b0;
      cfg_len = 8'd0; cfg_tiles = 8'd0;
      model_reset();
      #1 check_all("reset");
      @(posedge clk);
      #1 reset = 1'b0;

      run_default_job("t1");

      cfg_len = 8'd3; cfg_tiles = 8'd4;
      tick("t2.start", 1, 0, 1, 0);
      hs_cnt = 0; ad_cnt = 0;
      for (int i = 0; i < 12; i++) tick("t2.pulse", 0, 1, 1, 0);
      for (int i = 0; i < 3; i++) tick("t2.drain", 0, 0, 1, 0);
      chk("t2.handshakes", 32'(hs_cnt), 32'd4);
      chk("t2.all_done_pulses", 32'(ad_cnt), 32'd1);

      cfg_len = 8'd2; cfg_tiles = 8'd1;
      tick("t3.start", 1, 0, 0, 0);
      tick("t3.p1", 0, 1, 0, 0);
      tick("t3.p2", 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) tick("t3.stall", 0, (i == 1), 0, 0);
      chk("t3.ovf", 32'(err_ovf), 32'd1);
      chk("t3.count_held", 32'(count), 32'd2);
      tick("t3.hs", 0, 0, 1, 0);
      tick("t3.fin", 0, 0, 1, 0);
      chk("t3.ovf_sticky", 32'(err_ovf), 32'd1);

      tick("t4.clr", 0, 0, 0, 1);
      cfg_len = 8'd2; cfg_tiles = 8'd2;
      tick("t4.start", 1, 0, 0, 0);
      tick("t4.p1", 0, 1, 0, 0);
      tick("t4.p2", 0, 1, 0, 0);
      tick("t4.hs_done", 0, 1, 1, 0);
      chk("t4.count1", 32'(count), 32'd1);
      tick("t4.p3", 0, 1, 0, 0);
      chk("t4.en_y2", 32'(en_y), 32'd1);
      tick("t4.hs2", 0, 0, 1, 0);
      tick("t4.fin", 0, 0, 1, 0);
      chk("t4.no_ovf", 32'(err_ovf), 32'd0);

      cfg_len = 8'd5; cfg_tiles = 8'd1;
      tick("t5.start", 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) tick("t5.pulse", 0, 1, 0, 0);
      async_rst("t5.rst");
      cfg_len = 8'd2;
      tick("t5.start2", 1, 0, 0, 0);
      tick("t5.q1", 0, 1, 0, 0);
      tick("t5.q2", 0, 1, 0, 0);
      tick("t5.clr_start", 1, 0, 0, 1);
      chk("t5.clr_en_y", 32'(en_y), 32'd0);
      run_default_job("t5.rerun");

      cfg_len = 8'd1; cfg_tiles = 8'd3;
      tick("t6.start", 1, 0, 1, 0);
      hs_cnt = 0; ad_cnt = 0;
      for (int i = 0; i < 3; i++) tick("t6.pulse", 0, 1, 1, 0);
      for (int i = 0; i < 3; i++) tick("t6.drain", 0, 0, 1, 0);
      chk("t6.handshakes", 32'(hs_cnt), 32'd3);
      chk("t6.all_done_pulses", 32'(ad_cnt), 32'd1);
      chk("t6.no_ovf", 32'(err_ovf), 32'd0);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            cfg_len   = 8'($urandom_range(0, 4));
            cfg_tiles = 8'($urandom_range(0, 3));
         end
         if ($urandom_range(0, 499) == 0) begin
            async_rst("rnd.rst");
         end else begin
            tick("rnd",
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 1) == 0),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 149) == 0));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
